// File: rtl/snitch_cluster_hw_barrier.sv
// Cluster hardware barrier: holds barrier accesses until all
// participating cores arrive, then releases them together.
module snitch_cluster_hw_barrier #(
  parameter int unsigned NrCores    = 8,
  parameter int unsigned EpochWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrCores-1:0]    barrier_req_valid_i,
  output logic [NrCores-1:0]    barrier_req_ready_o,
  output logic [NrCores-1:0]    barrier_rsp_valid_o,
  input  logic [NrCores-1:0]    barrier_rsp_ready_i,
  input  logic [NrCores-1:0]    participant_mask_i,
  output logic [NrCores-1:0]    arrived_o,
  output logic [EpochWidth-1:0] epoch_o,
  output logic [NrCores-1:0]    barrier_stall_o
);

  typedef enum logic [1:0] {
    Idle,
    Gather,
    Release
  } state_e;

  typedef logic [NrCores-1:0] core_vec_t;

  state_e    state_q, state_d;
  core_vec_t arrived_q, arrived_d;
  core_vec_t np_pend_q, np_pend_d;
  core_vec_t mask_q, mask_d;
  logic [EpochWidth-1:0] epoch_q, epoch_d;

  core_vec_t live_mask;
  core_vec_t member;
  core_vec_t accept;
  core_vec_t join_v;
  core_vec_t rsp_fire;
  core_vec_t gathered;
  logic      in_rel;

  // Before the mask is latched, membership follows the live mask.
  assign live_mask = (participant_mask_i == '0) ? '1 : participant_mask_i;
  assign member    = (state_q == Idle) ? live_mask : mask_q;
  assign in_rel    = (state_q == Release);

  assign barrier_req_ready_o =
    ~arrived_q & ~np_pend_q & {NrCores{~in_rel}};
  assign barrier_rsp_valid_o =
    np_pend_q | (arrived_q & {NrCores{in_rel}});

  assign accept   = barrier_req_valid_i & barrier_req_ready_o;
  assign join_v   = accept & member;
  assign rsp_fire = barrier_rsp_valid_o & barrier_rsp_ready_i;
  assign gathered = arrived_q | join_v;

  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    epoch_d   = epoch_q;
    np_pend_d = (np_pend_q & ~rsp_fire) | (accept & ~member);
    unique case (state_q)
      Idle: begin
        if (|join_v) begin
          mask_d    = live_mask;
          arrived_d = join_v;
          state_d   = (join_v == live_mask) ? Release : Gather;
        end
      end
      Gather: begin
        arrived_d = gathered;
        if (gathered == mask_q) begin
          state_d = Release;
        end
      end
      Release: begin
        arrived_d = arrived_q & ~rsp_fire;
        if (arrived_d == '0) begin
          state_d = Idle;
          epoch_d = epoch_q + EpochWidth'(1);
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      arrived_q <= '0;
      np_pend_q <= '0;
      mask_q    <= '0;
      epoch_q   <= '0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      np_pend_q <= np_pend_d;
      mask_q    <= mask_d;
      epoch_q   <= epoch_d;
    end
  end

  assign arrived_o       = arrived_q;
  assign epoch_o         = epoch_q;
  assign barrier_stall_o = arrived_q | np_pend_q;

endmodule

// File: tb/tb_snitch_cluster_hw_barrier.sv
// Scoreboard bench for the cluster hardware barrier with a
// count-based reference model and directed plus random stimulus.
module tb_snitch_cluster_hw_barrier;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_v, req_r, rsp_v, rsp_r, pmask, arr, stall;
  logic [31:0] epoch;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snitch_cluster_hw_barrier #(
    .NrCores(N),
    .EpochWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .barrier_req_valid_i (req_v),
    .barrier_req_ready_o (req_r),
    .barrier_rsp_valid_o (rsp_v),
    .barrier_rsp_ready_i (rsp_r),
    .participant_mask_i  (pmask),
    .arrived_o           (arr),
    .epoch_o             (epoch),
    .barrier_stall_o     (stall)
  );

  // Model: phase 0 = waiting for first arrival, 1 = collecting,
  // 2 = handing out responses. Progress is tracked by counts.
  int m_phase, m_need, m_got, m_left;
  logic [7:0] m_mask, m_in, m_np;
  logic [31:0] m_epoch;
  logic [32:0] sbq [N][$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_need = 0; m_got = 0; m_left = 0;
    m_mask = '0; m_in = '0; m_np = '0; m_epoch = '0;
    for (int i = 0; i < N; i++) sbq[i].delete();
  endtask

  function automatic logic [7:0] m_ready();
    logic [7:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (m_phase != 2) && !m_in[i] && !m_np[i];
    return r;
  endfunction

  function automatic logic [7:0] m_rspv();
    logic [7:0] r;
    for (int i = 0; i < N; i++)
      r[i] = m_np[i] || (m_phase == 2 && m_in[i]);
    return r;
  endfunction

  task automatic model_update(logic [7:0] v, logic [7:0] r,
                              logic [7:0] pm);
    logic [7:0] rdy, memb, rv;
    int joins, done;
    rdy = m_ready();
    rv = m_rspv();
    memb = (m_phase == 0) ? ((pm == 0) ? 8'hFF : pm) : m_mask;
    joins = 0;
    done = 0;
    for (int i = 0; i < N; i++) begin
      if (rv[i] && r[i]) begin
        if (m_np[i]) m_np[i] = 1'b0;
        else begin m_in[i] = 1'b0; done++; end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && rdy[i]) begin
        if (memb[i]) begin
          m_in[i] = 1'b1; joins++;
          sbq[i].push_back({1'b1, m_epoch});
        end else begin
          m_np[i] = 1'b1;
          sbq[i].push_back({1'b0, 32'h0});
        end
      end
    end
    if (m_phase == 0 && joins > 0) begin
      m_mask = memb;
      m_need = $countones(memb);
      m_got = joins;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_got += joins;
    end
    if (m_phase == 1 && m_got == m_need) begin
      m_phase = 2;
      m_left = m_need;
    end else if (m_phase == 2) begin
      m_left -= done;
      if (m_left == 0) begin
        m_phase = 0;
        m_epoch = m_epoch + 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready", 32'(req_r), 32'(m_ready()));
    chk("rsp_valid", 32'(rsp_v), 32'(m_rspv()));
    chk("arrived", 32'(arr), 32'(m_in));
    chk("epoch", epoch, m_epoch);
    chk("stall", 32'(stall), 32'(m_in | m_np));
  endtask

  task automatic step(logic [7:0] v, logic [7:0] r, logic [7:0] pm);
    check_outputs();
    req_v = v;
    rsp_r = r;
    pmask = pm;
    model_update(v, r, pm);
    @(negedge clk);
  endtask

  // Monitor: pops the expected response on every response handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_v[i] && rsp_r[i]) begin
          chk("sb_nonempty", 32'(sbq[i].size() > 0), 32'd1);
          if (sbq[i].size() > 0) begin
            logic [32:0] it;
            it = sbq[i].pop_front();
            chk("rsp_kind", 32'(arr[i]), 32'(it[32]));
            if (it[32]) chk("rsp_epoch", epoch, it[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tot;
    req_v = '0; rsp_r = '0; pmask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_r), 32'hFF);
    chk("rst_rsp_valid", 32'(rsp_v), 32'h0);
    chk("rst_arrived", 32'(arr), 32'h0);
    chk("rst_epoch", epoch, 32'h0);

    for (int i = 0; i < N; i++) begin
      step(8'(1 << i), 8'h00, 8'hFF);
      if (i == 6) chk("full_arr7f", 32'(arr), 32'h7F);
    end
    chk("full_rspv", 32'(rsp_v), 32'hFF);
    step(8'h00, 8'hFF, 8'hFF);
    chk("full_epoch", epoch, 32'd1);
    chk("full_ready", 32'(req_r), 32'hFF);

    step(8'h01, 8'h00, 8'h0F);
    step(8'h20, 8'h00, 8'hFF);
    chk("np_rspv", 32'(rsp_v), 32'h20);
    chk("np_arr", 32'(arr), 32'h01);
    step(8'h00, 8'h20, 8'h0F);
    step(8'h0E, 8'h00, 8'h0F);
    chk("part_rspv", 32'(rsp_v), 32'h0F);
    step(8'h00, 8'h0F, 8'h0F);
    chk("part_epoch", epoch, 32'd2);

    step(8'hFF, 8'h00, 8'hFF);
    chk("simul_rspv", 32'(rsp_v), 32'hFF);
    step(8'h01, 8'hF7, 8'hFF);
    chk("reenter_held", 32'(req_r), 32'h00);
    repeat (4) step(8'h01, 8'h00, 8'hFF);
    step(8'h01, 8'h08, 8'hFF);
    chk("reenter_ready", 32'(req_r), 32'hFF);
    step(8'h01, 8'h00, 8'hFF);
    chk("reenter_arr", 32'(arr), 32'h01);
    step(8'hFE, 8'h00, 8'hFF);
    step(8'h00, 8'hFF, 8'hFF);
    chk("reenter_epoch", epoch, 32'd4);

    step(8'hFF, 8'h00, 8'h00);
    chk("mask0_rspv", 32'(rsp_v), 32'hFF);
    step(8'h00, 8'hFF, 8'h00);
    step(8'h04, 8'h00, 8'h04);
    chk("single_rspv", 32'(rsp_v), 32'h04);
    step(8'h00, 8'h04, 8'h04);
    chk("single_epoch", epoch, 32'd6);

    force dut.epoch_q = 32'hFFFF_FFFF;
    #1;
    release dut.epoch_q;
    m_epoch = 32'hFFFF_FFFF;
    step(8'h04, 8'h00, 8'h04);
    step(8'h00, 8'h04, 8'h04);
    chk("epoch_wrap", epoch, 32'h0);

    step(8'h07, 8'h00, 8'hFF);
    step(8'h00, 8'h00, 8'hFF);
    rst_n = 1'b0;
    req_v = '0; rsp_r = '0;
    model_reset();
    @(negedge clk);
    chk("midrst_arr", 32'(arr), 32'h0);
    chk("midrst_rspv", 32'(rsp_v), 32'h0);
    chk("midrst_epoch", epoch, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    step(8'hFF, 8'h00, 8'hFF);
    step(8'h00, 8'hFF, 8'hFF);
    chk("midrst_next", epoch, 32'd1);

    for (int c = 0; c < 1500; c++) begin
      logic [7:0] pm;
      case ($urandom_range(3))
        0: pm = 8'h00;
        1: pm = 8'hFF;
        default: pm = 8'($urandom);
      endcase
      step(8'($urandom), 8'($urandom), pm);
    end

    for (int c = 0; c < 40 && !(m_phase == 0 && m_np == 0); c++)
      step((m_phase == 1) ? 8'hFF : 8'h00, 8'hFF, 8'hFF);
    check_outputs();
    chk("drain_ready", 32'(req_r), 32'hFF);
    tot = 0;
    for (int i = 0; i < N; i++) tot += sbq[i].size();
    chk("drain_sb_empty", 32'(tot), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
